// File: rtl/sequ_pattern_gen_101_0110.sv
// sequ_pattern_gen_101_0110
//   Command-driven serial transmitter for the framed patterns "101" and
//   "0110", sent MSB first, one bit per clock. Each command sends
//   cmd_repeat+1 frames, with cmd_gap idle bit-times between frames.
//
// Ports:
//   clk        rising-edge clock, one serial bit per cycle
//   reset      synchronous, active-low reset
//   cmd_valid  command request
//   cmd_ready  command accept (combinational)
//   cmd_sel    0: "101", 1: "0110"
//   cmd_repeat additional frames after the first
//   cmd_gap    idle cycles between consecutive frames
//   abort      synchronous cancel of the current command
//   out        serial data bit (registered)
//   out_valid  out carries a pattern bit (registered)
//   busy       high while sending or in a gap (registered)
//   frame_done pulse with the last bit of every frame
//   done       pulse with the last bit of the last frame
module sequ_pattern_gen_101_0110 #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sel,
    input  logic [CNT_W-1:0] cmd_repeat,
    input  logic [GAP_W-1:0] cmd_gap,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]       state;
    logic             sel_q;
    logic [GAP_W-1:0] gap_q;
    logic [CNT_W-1:0] frames_left;
    logic [GAP_W-1:0] gap_cnt;
    // Bits still to send after the one currently on out, left-aligned.
    logic [2:0]       shreg;
    logic [1:0]       bits_left;

    // Frame load values: from the command port when accepting, otherwise
    // from the latched selection when starting a repeat frame.
    logic       ld_sel;
    logic       ld_first;
    logic [2:0] ld_rest;
    logic [1:0] ld_left;

    always_comb begin
        ld_sel   = (state == IDLE) ? cmd_sel : sel_q;
        ld_first = ~ld_sel;
        ld_rest  = ld_sel ? 3'b110 : 3'b010;
        ld_left  = ld_sel ? 2'd3 : 2'd2;
    end

    assign cmd_ready = (state == IDLE) && !abort && reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            sel_q       <= 1'b0;
            gap_q       <= '0;
            frames_left <= '0;
            gap_cnt     <= '0;
            shreg       <= '0;
            bits_left   <= '0;
            out         <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            done        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        sel_q       <= cmd_sel;
                        gap_q       <= cmd_gap;
                        frames_left <= cmd_repeat;
                        state       <= SEND;
                        out         <= ld_first;
                        shreg       <= ld_rest;
                        bits_left   <= ld_left;
                        out_valid   <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state     <= IDLE;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (bits_left != 2'd0) begin
                        out       <= shreg[2];
                        shreg     <= {shreg[1:0], 1'b0};
                        bits_left <= bits_left - 2'd1;
                        if (bits_left == 2'd1) begin
                            frame_done <= 1'b1;
                            done       <= (frames_left == '0);
                        end
                    end else if (frames_left == '0) begin
                        state     <= IDLE;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (gap_q == '0) begin
                        // Back-to-back frame: reload without an idle bit.
                        frames_left <= frames_left - 1'b1;
                        out         <= ld_first;
                        shreg       <= ld_rest;
                        bits_left   <= ld_left;
                    end else begin
                        frames_left <= frames_left - 1'b1;
                        gap_cnt     <= gap_q;
                        state       <= GAP;
                        out         <= 1'b0;
                        out_valid   <= 1'b0;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state     <= IDLE;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (gap_cnt == {{(GAP_W-1){1'b0}}, 1'b1}) begin
                        // Last gap cycle: first bit of next frame follows.
                        state     <= SEND;
                        out       <= ld_first;
                        shreg     <= ld_rest;
                        bits_left <= ld_left;
                        out_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequ_pattern_gen_101_0110.sv
// Testbench for sequ_pattern_gen_101_0110: scenario tasks compared against
// a per-cycle expected stream built from the pattern/repeat/gap rules.
module tb_sequ_pattern_gen_101_0110;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_sel = 1'b0;
    logic [3:0] cmd_repeat = '0;
    logic [3:0] cmd_gap = '0;
    logic       abort = 1'b0;
    logic       out, out_valid, busy, frame_done, done;

    int checks = 0;
    int failures = 0;

    // Expected per-cycle {out, out_valid, busy, frame_done, done}
    logic [4:0] exp_q[$];
    logic [4:0] obs;

    sequ_pattern_gen_101_0110 #(.CNT_W(4), .GAP_W(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_repeat(cmd_repeat), .cmd_gap(cmd_gap),
        .abort(abort), .out(out), .out_valid(out_valid), .busy(busy),
        .frame_done(frame_done), .done(done)
    );

    always #5 clk = ~clk;

    assign obs = {out, out_valid, busy, frame_done, done};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference: frames of the chosen pattern, gap-filled between frames.
    task automatic build_stream(input logic sel, input int unsigned rep,
                                input int unsigned gap);
        int         len;
        logic [3:0] pat;
        len = sel ? 4 : 3;
        pat = sel ? 4'd6 : 4'd5;
        exp_q.delete();
        for (int unsigned f = 0; f <= rep; f++) begin
            for (int b = len - 1; b >= 0; b--)
                exp_q.push_back({pat[b], 1'b1, 1'b1, b == 0, (b == 0) && (f == rep)});
            if (f < rep)
                for (int unsigned g = 0; g < gap; g++)
                    exp_q.push_back(5'b00100);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 5'b0);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 0", cmd_ready);
        end
        reset = 1'b1;
        cmd_valid = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
        @(posedge clk); #2;
        checks++;
        if (obs !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle: got %b expected %b", obs, 5'b0);
        end
    endtask

    task automatic test_single(input logic sel, input int unsigned rep,
                               input int unsigned gap, input string name);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_sel = sel;
        cmd_repeat = 4'(rep); cmd_gap = 4'(gap); abort = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept_ready: got %b expected 1", name, cmd_ready);
        end
        build_stream(sel, rep, gap);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0; cmd_sel = 1'($urandom);
            cmd_repeat = 4'($urandom); cmd_gap = 4'($urandom);
            #1;
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, i, obs, exp_q[i]);
            end
            checks++;
            if (cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s busy_ready cycle %0d: got %b expected 0", name, i, cmd_ready);
            end
        end
        @(posedge clk); #2;
        checks++;
        if (obs !== 5'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s after_done: got %b ready %b expected 00000 ready 1",
                     name, obs, cmd_ready);
        end
    endtask

    task automatic test_back_to_back(input logic sel_a, input int unsigned rep,
                                     input int unsigned gap);
        logic [4:0] b_q[$];
        logic       sel_b;
        sel_b = ~sel_a;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_sel = sel_a;
        cmd_repeat = 4'(rep); cmd_gap = 4'(gap);
        #1;
        build_stream(sel_a, rep, gap);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1; cmd_sel = sel_b; cmd_repeat = 4'd0; cmd_gap = 4'd0;
            #1;
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_first cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
        end
        // First idle cycle after done: still idle, second command is accepted here.
        @(posedge clk); #2;
        checks++;
        if (obs !== 5'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle_gap: got %b ready %b expected 00000 ready 1", obs, cmd_ready);
        end
        build_stream(sel_b, 0, 0);
        b_q = exp_q;
        for (int i = 0; i < b_q.size(); i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            #1;
            checks++;
            if (obs !== b_q[i]) begin
                failures++;
                $display("FAIL b2b_second cycle %0d: got %b expected %b", i, obs, b_q[i]);
            end
        end
        @(posedge clk); #2;
        checks++;
        if (obs !== 5'b0) begin
            failures++;
            $display("FAIL b2b_end: got %b expected 00000", obs);
        end
    endtask

    task automatic test_abort();
        int unsigned g;
        int          k;
        g = $urandom_range(0, 4);
        k = 5 + int'(g);  // second bit of the second frame
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_sel = 1'b1; cmd_repeat = 4'd3; cmd_gap = 4'(g);
        #1;
        build_stream(1'b1, 3, g);
        for (int i = 0; i <= k; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            abort = (i == k);
            #1;
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL abort_pre cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
        end
        @(posedge clk); #1;
        abort = 1'b1; cmd_valid = 1'b1; cmd_sel = 1'($urandom);
        #1;
        checks++;
        if (obs !== 5'b0) begin
            failures++;
            $display("FAIL abort_idle: got %b expected 00000", obs);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_blocks_ready: got %b expected 0", cmd_ready);
        end
        @(posedge clk); #1;
        abort = 1'b0; cmd_valid = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_no_accept: got %b ready %b expected 00000 ready 1", obs, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_sel = 1'b0; cmd_repeat = 4'd1; cmd_gap = 4'd3;
        #1;
        build_stream(1'b0, 1, 3);
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            reset = (i == 4) ? 1'b0 : 1'b1;
            #1;
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL rstmid_pre cycle %0d: got %b expected %b", i, obs, exp_q[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            reset = 1'b1;
            #1;
            checks++;
            if (obs !== 5'b0) begin
                failures++;
                $display("FAIL rstmid_quiet cycle %0d: got %b expected 00000", i, obs);
            end
        end
        test_single(1'b0, 0, 0, "rstmid_next");
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int unsigned idle;
            idle = $urandom_range(0, 3);
            for (int unsigned j = 0; j < idle; j++) begin
                @(posedge clk); #1;
                cmd_sel = 1'($urandom); cmd_repeat = 4'($urandom); cmd_gap = 4'($urandom);
            end
            test_single(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 15), "random");
        end
    endtask

    initial begin
        test_reset();
        test_single(1'b0, 0, 0, "s1_101_single");
        test_single(1'b1, 1, 0, "s2_0110_b2b");
        test_single(1'b0, 2, 2, "s3_101_gap2");
        test_abort();
        test_reset_mid();
        test_back_to_back(1'b0, 1, 1);
        test_single(1'b1, 15, 0, "max_repeat");
        test_single(1'b0, 15, 15, "max_repeat_gap");
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
